// File: rtl/man_tx_queue_if.sv
// Bundle between the SPI word source, the Manchester encoder and the TX queue.
// Valid/ready semantics: wr_flag is a one-cycle strobe that carries wr_data and is never back-pressured.
// enc_start is a one-cycle launch that carries enc_data; the encoder acknowledges it by raising enc_busy.
interface man_tx_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wr_flag;
    logic [0:15]      wr_data;
    logic             enc_busy;
    logic             enc_start;
    logic [0:15]      enc_data;
    logic [CNT_W-1:0] fifo_count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             ack_err;
    logic [2:0]       dbg_state;

    modport master (
        output wr_flag,
        output wr_data,
        output enc_busy,
        input  enc_start,
        input  enc_data,
        input  fifo_count,
        input  full,
        input  empty,
        input  overflow,
        input  ack_err,
        input  dbg_state
    );

    modport slave (
        input  wr_flag,
        input  wr_data,
        input  enc_busy,
        output enc_start,
        output enc_data,
        output fifo_count,
        output full,
        output empty,
        output overflow,
        output ack_err,
        output dbg_state
    );
endinterface

// File: rtl/man_tx_queue.sv
// Queues 16-bit words from the SPI receiver and launches them one at a time into a
// Manchester encoder, with an acknowledge timeout and a fixed inter-frame gap.
module man_tx_queue #(
    parameter int DEPTH       = 4,
    parameter int GAP_CYCLES  = 36,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic          clk_in,
    input  logic          rst,
    man_tx_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_e;

    state_e           state_q,     state_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             enc_start_q, enc_start_d;
    logic [0:15]      enc_data_q,  enc_data_d;
    logic [ACK_W-1:0] ack_tmr_q,   ack_tmr_d;
    logic [GAP_W-1:0] gap_tmr_q,   gap_tmr_d;
    logic             overflow_q,  overflow_d;
    logic             ack_err_q,   ack_err_d;

    logic [0:15]      mem_q [DEPTH];

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             drop;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);

    // Launch sequencer; pop is asserted only from IDLE so the FIFO logic can see it.
    always_comb begin
        state_d     = state_q;
        enc_start_d = 1'b0;
        enc_data_d  = enc_data_q;
        ack_tmr_d   = ack_tmr_q;
        gap_tmr_d   = gap_tmr_q;
        ack_err_d   = ack_err_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    enc_data_d  = mem_q[rd_ptr_q];
                    enc_start_d = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                ack_tmr_d = '0;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (bus.enc_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (ack_tmr_q == ACK_LAST) begin
                    ack_err_d = 1'b1;
                    gap_tmr_d = '0;
                    state_d   = S_GAP;
                end else begin
                    ack_tmr_d = ack_tmr_q + ACK_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!bus.enc_busy) begin
                    gap_tmr_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_tmr_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_tmr_d = gap_tmr_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a write on a full FIFO still lands.
    always_comb begin
        push       = bus.wr_flag && (!fifo_full || pop);
        drop       = bus.wr_flag && fifo_full && !pop;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            enc_start_q <= 1'b0;
            enc_data_q  <= 16'h0000;
            ack_tmr_q   <= '0;
            gap_tmr_q   <= '0;
            overflow_q  <= 1'b0;
            ack_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            enc_start_q <= enc_start_d;
            enc_data_q  <= enc_data_d;
            ack_tmr_q   <= ack_tmr_d;
            gap_tmr_q   <= gap_tmr_d;
            overflow_q  <= overflow_d;
            ack_err_q   <= ack_err_d;
        end
    end

    // Storage carries no reset; empty slots are never read.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.enc_start  = enc_start_q;
    assign bus.enc_data   = enc_data_q;
    assign bus.fifo_count = count_q;
    assign bus.full       = fifo_full;
    assign bus.empty      = fifo_empty;
    assign bus.overflow   = overflow_q;
    assign bus.ack_err    = ack_err_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_man_tx_queue.sv
// Bench for man_tx_queue: encoder model, enc_start monitor with expected-word queue,
// and directed scenarios for latency, burst, timeout, full-with-pop, overflow and reset.
module tb_man_tx_queue;
    localparam int DEPTH = 4;
    localparam int GAP   = 36;
    localparam int ACK   = 15;
    localparam int W     = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;

    man_tx_queue_if #(.DEPTH(DEPTH)) bus ();

    man_tx_queue #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .ACK_TIMEOUT(ACK)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    // ---------------- bookkeeping ----------------
    int         passed = 0;
    int         total  = 0;
    logic [W-1:0] exp_q[$];
    int         start_hist[$];
    int         start_cnt      = 0;
    int         last_start_cyc = 0;
    int         wr_cyc         = 0;
    logic       prev_start     = 1'b0;

    int busy_len = 8;
    bit enc_dead = 1'b0;
    bit enc_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout_fail(input string name);
        total++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // ---------------- encoder model ----------------
    initial begin
        bus.enc_busy = 1'b0;
        forever begin
            @(negedge clk_in);
            if (rst && bus.enc_start && !enc_dead) begin
                @(posedge clk_in);
                #1 bus.enc_busy = 1'b1;
                if (enc_hold) begin
                    while (enc_hold) @(posedge clk_in);
                end else begin
                    repeat (busy_len) @(posedge clk_in);
                end
                #1 bus.enc_busy = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_in) begin
        if (rst) begin
            if (bus.enc_start) begin
                start_cnt++;
                last_start_cyc = cyc;
                start_hist.push_back(cyc);
                check("start_not_back_to_back", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_enc_start");
                end else begin
                    check("enc_data", 32'(bus.enc_data), 32'(exp_q.pop_front()));
                end
            end
            prev_start = bus.enc_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_word(input logic [W-1:0] d, input bit launches);
        @(posedge clk_in);
        #1;
        bus.wr_flag = 1'b1;
        bus.wr_data = d;
        wr_cyc      = cyc;
        if (launches) exp_q.push_back(d);
        @(posedge clk_in);
        #1 bus.wr_flag = 1'b0;
    endtask

    task automatic burst(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            bus.wr_flag = 1'b1;
            bus.wr_data = base + W'(i);
            if (i == 0) wr_cyc = cyc;
        end
        @(posedge clk_in);
        #1 bus.wr_flag = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int t = 0;
        while (start_cnt < n && t < budget) begin
            @(negedge clk_in);
            t++;
        end
        if (start_cnt < n) timeout_fail(tag);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int t = 0;
        @(negedge clk_in);
        while (bus.dbg_state !== st && t < budget) begin
            @(negedge clk_in);
            t++;
        end
        if (bus.dbg_state !== st) timeout_fail(tag);
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int t = 0;
        @(negedge clk_in);
        while (!(bus.dbg_state === ST_IDLE && bus.empty === 1'b1 && bus.enc_busy === 1'b0) && t < budget) begin
            @(negedge clk_in);
            t++;
        end
        if (!(bus.dbg_state === ST_IDLE && bus.empty === 1'b1)) timeout_fail(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"},     32'(bus.fifo_count), 32'd0);
        check({tag, "_empty"},     32'(bus.empty),      32'd1);
        check({tag, "_full"},      32'(bus.full),       32'd0);
        check({tag, "_enc_start"}, 32'(bus.enc_start),  32'd0);
        check({tag, "_enc_data"},  32'(bus.enc_data),   32'h0000);
        check({tag, "_overflow"},  32'(bus.overflow),   32'd0);
        check({tag, "_ack_err"},   32'(bus.ack_err),    32'd0);
        check({tag, "_state"},     32'(bus.dbg_state),  32'(ST_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int s0;
        int idle_cyc;
        int s_first;

        bus.wr_flag = 1'b0;
        bus.wr_data = '0;

        // reset state
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_values("por");
        rst = 1'b1;

        // single word: latency 2, return to IDLE after busy + gap
        busy_len = 64;
        write_word(16'hA5C3, 1'b1);
        wait_starts(1, 20, "single_start");
        check("single_latency", 32'(last_start_cyc - wr_cyc), 32'd2);
        idle_cyc = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk_in);
            if (bus.dbg_state === ST_IDLE) begin
                idle_cyc = cyc;
                break;
            end
        end
        check("single_idle_after_gap", 32'(idle_cyc - last_start_cyc), 32'(64 + GAP + 2));
        check("single_empty", 32'(bus.empty), 32'd1);

        // burst of four back-to-back writes
        busy_len = 8;
        s0 = start_cnt;
        for (int i = 1; i <= 4; i++) exp_q.push_back(W'(i));
        burst(16'h0001, 4);
        wait_starts(s0 + 4, 4 * (8 + GAP + 10), "burst_starts");
        for (int i = 1; i < 4; i++) begin
            check("burst_spacing", 32'((start_hist[s0 + i] - start_hist[s0 + i - 1]) >= (8 + GAP + 2)), 32'd1);
        end
        wait_quiet(200, "burst_drain");
        check("burst_start_count", 32'(start_cnt - s0), 32'd4);

        // acknowledge timeout, then recovery for the next queued word
        enc_dead = 1'b1;
        s0 = start_cnt;
        write_word(16'h0BAD, 1'b1);
        write_word(16'h0C0D, 1'b1);
        wait_starts(s0 + 1, 20, "ack_first_start");
        s_first = last_start_cyc;
        while (cyc < s_first + ACK) @(negedge clk_in);
        check("ack_err_before_timeout", 32'(bus.ack_err), 32'd0);
        check("ack_state_before_timeout", 32'(bus.dbg_state), 32'(ST_WAIT_ACK));
        @(negedge clk_in);
        check("ack_err_at_timeout", 32'(bus.ack_err), 32'd1);
        check("ack_state_gap", 32'(bus.dbg_state), 32'(ST_GAP));
        wait_starts(s0 + 2, 200, "ack_second_start");
        wait_quiet(200, "ack_drain");
        check("ack_err_sticky", 32'(bus.ack_err), 32'd1);
        enc_dead = 1'b0;

        // full FIFO with a write coincident with the IDLE pop
        enc_hold = 1'b1;
        s0 = start_cnt;
        for (int i = 0; i < 6; i++) exp_q.push_back(16'h0021 + W'(i));
        burst(16'h0021, 5);
        @(negedge clk_in);
        check("fwp_full_count", 32'(bus.fifo_count), 32'd4);
        check("fwp_full_flag", 32'(bus.full), 32'd1);
        check("fwp_no_overflow_yet", 32'(bus.overflow), 32'd0);
        enc_hold = 1'b0;
        wait_state(ST_IDLE, 200, "fwp_reach_idle");
        check("fwp_idle_count", 32'(bus.fifo_count), 32'd4);
        bus.wr_flag = 1'b1;
        bus.wr_data = 16'h0026;
        @(posedge clk_in);
        #1 bus.wr_flag = 1'b0;
        @(negedge clk_in);
        check("fwp_count_stays", 32'(bus.fifo_count), 32'd4);
        check("fwp_overflow_clear", 32'(bus.overflow), 32'd0);
        wait_starts(s0 + 6, 6 * (8 + GAP + 10), "fwp_drain_starts");
        wait_quiet(200, "fwp_drain");

        // overflow: six writes while the encoder is held busy
        enc_hold = 1'b1;
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) exp_q.push_back(16'h0011 + W'(i));
        burst(16'h0011, 6);
        @(negedge clk_in);
        check("ovf_count", 32'(bus.fifo_count), 32'd4);
        check("ovf_full", 32'(bus.full), 32'd1);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        enc_hold = 1'b0;
        wait_starts(s0 + 5, 5 * (8 + GAP + 10), "ovf_drain_starts");
        wait_quiet(200, "ovf_drain");
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        check("ovf_drained_count", 32'(start_cnt - s0), 32'd5);

        // reset during WAIT_DONE with two words queued
        enc_hold = 1'b1;
        s0 = start_cnt;
        exp_q.push_back(16'h0031);
        burst(16'h0031, 3);
        wait_state(ST_WAIT_DONE, 40, "rst_reach_wait_done");
        check("rst_queued_count", 32'(bus.fifo_count), 32'd2);
        rst = 1'b0;
        #1;
        check_reset_values("mid_rst");
        enc_hold = 1'b0;
        repeat (3) @(negedge clk_in);
        rst = 1'b1;
        s0 = start_cnt;
        repeat (50) @(negedge clk_in);
        check("rst_no_launch", 32'(start_cnt - s0), 32'd0);
        check("rst_still_empty", 32'(bus.empty), 32'd1);
        write_word(16'h0041, 1'b1);
        wait_starts(s0 + 1, 20, "rst_new_start");
        check("rst_new_latency", 32'(last_start_cyc - wr_cyc), 32'd2);
        wait_quiet(200, "rst_final_drain");
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/man_tx_queue.md
MAN_TX_QUEUE -- requirements
Module: man_tx_queue

Interface
REQ-001 Parameter: DEPTH, 4, FIFO word capacity; power of two, 2..16.
REQ-002 Parameter: GAP_CYCLES, 36, idle clk_in cycles between frames (3 us at 12 MHz).
REQ-003 Parameter: ACK_TIMEOUT, 15, max cycles from enc_start to enc_busy rising.
REQ-004 Port: clk_in  input  1  system clock, 12 MHz; single clock domain.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: wr_flag  input  1  one-cycle write strobe from the 16-bit SPI receiver (rx_flag).
REQ-007 Port: wr_data  input  16  word to queue, declared [0:15]; bit 0 is the first bit transmitted.
REQ-008 Port: enc_busy  input  1  high while the Manchester encoder is serialising a frame.
REQ-009 Port: enc_start  output  1  one-cycle frame-launch pulse to the encoder.
REQ-010 Port: enc_data  output  16  word for the encoder, [0:15], held stable from enc_start until enc_busy falls.
REQ-011 Port: fifo_count  output  clog2(DEPTH)+1  number of stored words.
REQ-012 Port: full / empty  output  1 each  fifo_count==DEPTH / fifo_count==0.
REQ-013 Port: overflow  output  1  sticky: a write was dropped.
REQ-014 Port: ack_err  output  1  sticky: encoder failed to assert enc_busy within ACK_TIMEOUT.

Function
REQ-015 Storage: circular buffer, DEPTH x 16, write and read pointers wrap modulo DEPTH.
REQ-016 Write: on a wr_flag edge with fifo_count<DEPTH, store wr_data at wr_ptr, increment wr_ptr and count.
REQ-017 Write when full without a same-cycle pop: word dropped, pointers/count unchanged, overflow set to 1.
REQ-018 Write when full with a same-cycle pop: write accepted, count stays DEPTH, overflow unchanged.
REQ-019 Simultaneous write and pop when not full: both performed, count unchanged.
REQ-020 FSM states: IDLE, START, WAIT_ACK, WAIT_DONE, GAP.
REQ-021 IDLE: if !empty, register enc_data<=head word, pop (rd_ptr+1, count-1), go to START.
REQ-022 START: enc_start=1 for exactly this cycle; clear ack timer; go to WAIT_ACK.
REQ-023 WAIT_ACK: enc_busy=1 -> WAIT_DONE; timer reaching ACK_TIMEOUT -> set ack_err, go to GAP.
REQ-024 WAIT_DONE: enc_busy=0 -> GAP with gap counter cleared.
REQ-025 GAP: count GAP_CYCLES cycles, then IDLE; no launch during GAP.
REQ-026 Latency: wr_flag high in cycle N with FSM in IDLE and FIFO empty -> enc_start high in cycle N+2.
REQ-027 enc_start is registered, glitch-free, never high in two consecutive cycles.
REQ-028 Writes are accepted in every FSM state.
REQ-029 full, empty and fifo_count reflect registered state, updated the cycle after the edge that changed it.

Reset
REQ-030 rst low asynchronously forces: FSM IDLE, pointers 0, fifo_count 0, empty 1, full 0, enc_start 0, enc_data 16'h0000, overflow 0, ack_err 0, timers 0.
REQ-031 Reset asserted mid-frame abandons the frame and discards all queued words; no enc_start within the first cycle after release.
REQ-032 overflow and ack_err clear only on reset.

Verification
REQ-033 Single word: rst release, wr_data=16'hA5C3 pulse in cycle N, encoder model busy for 64 cycles -> enc_start in N+2, enc_data=16'hA5C3, next IDLE after 36-cycle gap.
REQ-034 Burst: 4 back-to-back writes 16'h0001..16'h0004 -> enc_data sequence 0001,0002,0003,0004, one enc_start each, consecutive enc_start spacing >= encoder busy time + 36 + 2.
REQ-035 Overflow: encoder held busy, 6 writes with DEPTH=4 (one popped) -> full=1, overflow=1, fifth word kept, sixth dropped, pointer wrap verified on drain.
REQ-036 Ack timeout: enc_busy tied 0, one write -> ack_err=1 16 cycles after enc_start, FSM recovers, next queued word still launched.
REQ-037 Full-with-pop: FIFO full, write coincident with IDLE pop -> write accepted, count stays 4, overflow 0.
REQ-038 Reset mid-frame: rst low during WAIT_DONE with 2 words queued -> all outputs at REQ-030 values immediately; no enc_start until a new write.
